// File: rtl/boot_loader_ctrl.sv
// Command-frame loader: parses UART bytes into memory writes and run/halt control, then returns ACK/NAK.
// Latency: memory write one cycle after the 4th byte of a word; response one cycle after SUM at the earliest.
// Backpressure: the response waits in RESP while tx_ready is low; bytes arriving in RESP are dropped.
module boot_loader_ctrl #(
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_wr,
  output logic [7:0]  tx_din,
  output logic        insn_we,
  output logic [31:0] insn_addr,
  output logic [31:0] insn_din,
  output logic        data_we,
  output logic [31:0] data_addr,
  output logic [31:0] data_din,
  output logic        run,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [7:0] CMD_LOAD_INSN = 8'h01;
  localparam logic [7:0] CMD_LOAD_DATA = 8'h02;
  localparam logic [7:0] CMD_RUN       = 8'h10;
  localparam logic [7:0] CMD_HALT      = 8'h11;
  localparam logic [7:0] RESP_ACK      = 8'h06;
  localparam logic [7:0] RESP_NAK      = 8'h15;

  // S_SKIP swallows bytes of an unknown command until the idle timeout fires.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CNT,
    S_DATA,
    S_SUM,
    S_SKIP,
    S_RESP
  } state_t;

  state_t        state;
  logic [7:0]    cmd_q;
  logic          blocked;   // load received while the core runs: parse only, never write
  logic [1:0]    fidx;      // byte index within the current multi-byte field / word
  logic [31:0]   addr_ptr;  // byte address of the next word to write
  logic [15:0]   cnt;       // words still to receive
  logic [31:0]   shift;     // word assembly, LSB byte first
  logic [7:0]    sum;       // running XOR of the frame bytes so far
  logic [7:0]    resp;
  logic [TW-1:0] tmo;
  logic          parsing;
  logic [31:0]   word_next;

  // Parse states are the only ones subject to the inter-byte timeout.
  assign parsing   = (state == S_ADDR) || (state == S_CNT) || (state == S_DATA) ||
                     (state == S_SUM)  || (state == S_SKIP);
  assign word_next = {rx_data, shift[31:8]};
  assign busy      = (state != S_IDLE);

  // Frame parser, memory write strobes, run flag and response handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cmd_q     <= '0;
      blocked   <= 1'b0;
      fidx      <= '0;
      addr_ptr  <= '0;
      cnt       <= '0;
      shift     <= '0;
      sum       <= '0;
      resp      <= '0;
      tmo       <= '0;
      tx_wr     <= 1'b0;
      tx_din    <= '0;
      insn_we   <= 1'b0;
      insn_addr <= '0;
      insn_din  <= '0;
      data_we   <= 1'b0;
      data_addr <= '0;
      data_din  <= '0;
      run       <= 1'b0;
    end else begin
      insn_we <= 1'b0;
      data_we <= 1'b0;
      tx_wr   <= 1'b0;

      if (rx_valid) begin
        tmo <= '0;
      end else if (parsing) begin
        tmo <= tmo + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            cmd_q <= rx_data;
            sum   <= rx_data;
            fidx  <= '0;
            case (rx_data)
              CMD_LOAD_INSN, CMD_LOAD_DATA: begin
                blocked <= run;
                state   <= S_ADDR;
              end
              CMD_RUN, CMD_HALT: begin
                blocked <= 1'b0;
                state   <= S_SUM;
              end
              default: begin
                blocked <= 1'b0;
                state   <= S_SKIP;
              end
            endcase
          end
        end

        S_ADDR: begin
          if (rx_valid) begin
            sum  <= sum ^ rx_data;
            fidx <= fidx + 2'd1;
            if (fidx == 2'd3) begin
              // Word alignment: low address bits are discarded.
              addr_ptr <= {rx_data, addr_ptr[31:10], 2'b00};
              state    <= S_CNT;
            end else begin
              addr_ptr <= {rx_data, addr_ptr[31:8]};
            end
          end
        end

        S_CNT: begin
          if (rx_valid) begin
            sum <= sum ^ rx_data;
            if (fidx == 2'd0) begin
              cnt[7:0] <= rx_data;
              fidx     <= 2'd1;
            end else begin
              cnt   <= {rx_data, cnt[7:0]};
              fidx  <= 2'd0;
              state <= ({rx_data, cnt[7:0]} == 16'd0) ? S_SUM : S_DATA;
            end
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            sum   <= sum ^ rx_data;
            shift <= word_next;
            fidx  <= fidx + 2'd1;
            if (fidx == 2'd3) begin
              if (!blocked) begin
                if (cmd_q == CMD_LOAD_INSN) begin
                  insn_we   <= 1'b1;
                  insn_addr <= addr_ptr;
                  insn_din  <= word_next;
                end else begin
                  data_we   <= 1'b1;
                  data_addr <= addr_ptr;
                  data_din  <= word_next;
                end
              end
              addr_ptr <= addr_ptr + 32'd4;
              cnt      <= cnt - 16'd1;
              if (cnt == 16'd1) begin
                state <= S_SUM;
              end
            end
          end
        end

        S_SUM: begin
          if (rx_valid) begin
            if ((rx_data == sum) && !blocked) begin
              resp <= RESP_ACK;
              if (cmd_q == CMD_RUN) begin
                run <= 1'b1;
              end else if (cmd_q == CMD_HALT) begin
                run <= 1'b0;
              end
            end else begin
              resp <= RESP_NAK;
            end
            state <= S_RESP;
          end
        end

        S_SKIP: begin
          // Bytes are ignored; only the timeout below leaves this state.
        end

        S_RESP: begin
          // One extra cycle after the strobe keeps busy high through tx_wr.
          if (tx_wr) begin
            state <= S_IDLE;
          end else if (tx_ready) begin
            tx_wr  <= 1'b1;
            tx_din <= resp;
          end
        end

        default: state <= S_IDLE;
      endcase

      // Idle line inside a frame aborts it with a NAK.
      if (parsing && !rx_valid && (tmo == TMO_LAST)) begin
        resp  <= RESP_NAK;
        state <= S_RESP;
      end
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl: frame-level reference model with randomized loads and control frames.
// Latency: responses and writes observed on the falling edge after the producing rising edge.
// Backpressure: tx_ready driven low for a stretch to hold the response.
module tb_boot_loader_ctrl;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_ready = 1'b1;
  logic        tx_wr;
  logic [7:0]  tx_din;
  logic        insn_we;
  logic [31:0] insn_addr;
  logic [31:0] insn_din;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_din;
  logic        run;
  logic        busy;

  boot_loader_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_wr(tx_wr), .tx_din(tx_din),
    .insn_we(insn_we), .insn_addr(insn_addr), .insn_din(insn_din),
    .data_we(data_we), .data_addr(data_addr), .data_din(data_din),
    .run(run), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;   // 0 = instruction memory, 1 = data memory
    logic [31:0] addr;
    logic [31:0] din;
  } wr_t;

  wr_t        obs_wr[$];
  wr_t        exp_wr[$];
  logic [7:0] obs_tx[$];
  logic [7:0] frame[$];
  int         checks = 0;
  int         errors = 0;
  int         dual = 0;
  int         consec = 0;
  logic       prev_tx = 1'b0;
  bit         model_run = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Record every write strobe and response byte the DUT emits.
  always @(negedge clk) begin
    wr_t w;
    if (insn_we && data_we) dual++;
    if (insn_we) begin
      w.sel = 1'b0; w.addr = insn_addr; w.din = insn_din;
      obs_wr.push_back(w);
    end
    if (data_we) begin
      w.sel = 1'b1; w.addr = data_addr; w.din = data_din;
      obs_wr.push_back(w);
    end
    if (tx_wr) obs_tx.push_back(tx_din);
    if (tx_wr && prev_tx) consec++;
    prev_tx = tx_wr;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output logic we_seen);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    we_seen  = insn_we | data_we;
    repeat (gap) @(negedge clk);
  endtask

  task automatic push_sum(input bit bad);
    logic [7:0] x;
    x = '0;
    foreach (frame[i]) x ^= frame[i];
    if (bad) x ^= 8'($urandom_range(1, 255));
    frame.push_back(x);
  endtask

  task automatic make_load(input logic [7:0] cmd, input logic [31:0] addr, input int n, input bit bad);
    frame.delete();
    frame.push_back(cmd);
    for (int i = 0; i < 4; i++) frame.push_back(8'(addr >> (8 * i)));
    frame.push_back(8'(n));
    frame.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
    push_sum(bad);
  endtask

  // Predict the frame outcome from its bytes, send it, then compare everything observed.
  task automatic run_frame(input string tag);
    logic [7:0]  cmd, x, resp;
    logic [31:0] a;
    int          n, len, t;
    bit          ok, is_load, was_run;
    logic        we_seen, we_exp;
    wr_t         w;
    obs_wr.delete(); exp_wr.delete(); obs_tx.delete();
    len = frame.size();
    cmd = frame[0];
    x = '0;
    for (int i = 0; i < len - 1; i++) x ^= frame[i];
    ok = (x == frame[len-1]);
    is_load = (cmd == 8'h01) || (cmd == 8'h02);
    was_run = model_run;
    if (is_load) begin
      a = {frame[4], frame[3], frame[2], frame[1]} & 32'hFFFF_FFFC;
      n = {frame[6], frame[5]};
      if (!was_run)
        for (int k = 0; k < n; k++) begin
          w.sel  = (cmd == 8'h02);
          w.addr = a + 32'(4 * k);
          w.din  = {frame[10+4*k], frame[9+4*k], frame[8+4*k], frame[7+4*k]};
          exp_wr.push_back(w);
        end
      resp = (ok && !was_run) ? 8'h06 : 8'h15;
    end else begin
      resp = ok ? 8'h06 : 8'h15;
      if (ok) model_run = (cmd == 8'h10);
    end
    for (int i = 0; i < len; i++) begin
      send_byte(frame[i], $urandom_range(0, 3), we_seen);
      we_exp = is_load && !was_run && (i >= 7) && (i < len - 1) && (((i - 7) % 4) == 3);
      check({tag, "_we_lat"}, we_seen, we_exp);
    end
    t = 0;
    while (obs_tx.size() == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_resp_cnt"}, obs_tx.size(), 1);
    if (obs_tx.size() > 0) check({tag, "_resp"}, obs_tx[0], resp);
    repeat (2) @(negedge clk);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_run"}, run, model_run);
    check({tag, "_wr_cnt"}, obs_wr.size(), exp_wr.size());
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      check({tag, "_wr_sel"}, obs_wr[i].sel, exp_wr[i].sel);
      check({tag, "_wr_addr"}, obs_wr[i].addr, exp_wr[i].addr);
      check({tag, "_wr_din"}, obs_wr[i].din, exp_wr[i].din);
    end
  endtask

  // Abandon a frame after the listed bytes and expect a timeout NAK with no writes.
  task automatic timeout_case(input string tag);
    logic we_seen;
    int   n;
    obs_wr.delete(); obs_tx.delete();
    foreach (frame[i]) send_byte(frame[i], 0, we_seen);
    check({tag, "_busy_mid"}, busy, 1);
    n = 0;
    while (!tx_wr && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat_min"}, n >= int'(TO + 1), 1);
    check({tag, "_lat_max"}, n <= int'(TO + 4), 1);
    check({tag, "_nak"}, tx_din, 8'h15);
    repeat (3) @(negedge clk);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_no_wr"}, obs_wr.size(), 0);
    check({tag, "_run"}, run, model_run);
  endtask

  initial begin
    logic we_seen;
    int   kind;
    logic [31:0] a;

    repeat (3) @(negedge clk);
    check("rst_tx_wr", tx_wr, 0);
    check("rst_insn_we", insn_we, 0);
    check("rst_data_we", data_we, 0);
    check("rst_run", run, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", insn_addr, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Instruction load of two words at 0x100.
    frame = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00,
              8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    push_sum(0);
    run_frame("insn2");
    check("insn2_addr1", insn_addr, 32'h104);
    check("insn2_din1", insn_din, 32'hDEADBEEF);

    // Run, load while running, halt.
    frame = '{8'h10}; push_sum(0); run_frame("run");
    check("run_high", run, 1);
    make_load(8'h02, 32'h0, 1, 0); run_frame("load_running");
    frame = '{8'h11}; push_sum(0); run_frame("halt");
    check("run_low", run, 0);

    // Bad checksum on a one-word data load still writes.
    make_load(8'h02, 32'h40, 1, 1); run_frame("badsum");

    // Timeout mid-header and on an unknown command.
    frame = '{8'h01, 8'h00}; timeout_case("to_load");
    frame = '{8'h55, 8'hAA, 8'h01}; timeout_case("to_unknown");

    // Response held by tx_ready.
    obs_tx.delete();
    tx_ready = 1'b0;
    send_byte(8'h11, 0, we_seen);
    send_byte(8'h11, 0, we_seen);
    repeat (50) @(negedge clk);
    check("bp_held", obs_tx.size(), 0);
    check("bp_busy", busy, 1);
    tx_ready = 1'b1;
    @(negedge clk);
    check("bp_wr", tx_wr, 1);
    check("bp_din", tx_din, 8'h06);
    repeat (5) @(negedge clk);
    check("bp_one_pulse", obs_tx.size(), 1);
    model_run = 1'b0;

    // Reset in the middle of payload while the core runs.
    frame = '{8'h10}; push_sum(0); run_frame("run2");
    obs_wr.delete();
    frame = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
    foreach (frame[i]) send_byte(frame[i], 0, we_seen);
    #2 reset_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_run", run, 0);
    check("mrst_tx_wr", tx_wr, 0);
    check("mrst_insn_we", insn_we, 0);
    check("mrst_data_we", data_we, 0);
    check("mrst_daddr", data_addr, 0);
    check("mrst_no_wr", obs_wr.size(), 0);
    model_run = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    make_load(8'h01, 32'h200, 2, 0); run_frame("after_rst");

    // Randomized mix of frames, including address wrap and zero-length loads.
    for (int it = 0; it < 25; it++) begin
      kind = $urandom_range(0, 3);
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      case (kind)
        0: make_load(8'h01, a, $urandom_range(0, 4), $urandom_range(0, 3) == 0);
        1: make_load(8'h02, a, $urandom_range(0, 4), $urandom_range(0, 3) == 0);
        2: begin frame = '{8'h10}; push_sum($urandom_range(0, 3) == 0); end
        default: begin frame = '{8'h11}; push_sum($urandom_range(0, 3) == 0); end
      endcase
      run_frame("rand");
    end

    check("no_dual_we", dual, 0);
    check("no_consec_tx", consec, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
